// File: rtl/led_anim_pkg.sv
// Shared definitions for the LED animation front end: mode encodings,
// the mode type, the button FSM state encoding and the mode-advance helper.
package led_anim_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SHIFT = 2'd0;
  localparam mode_t MODE_FILL  = 2'd1;
  localparam mode_t MODE_PWM   = 2'd2;
  localparam mode_t MODE_OFF   = 2'd3;

  // Button FSM states: IDLE (released), PRESSED (long-press timer running),
  // LATCHED (held, nothing left to do until release).
  typedef enum logic [1:0] {
    FSM_IDLE    = 2'd0,
    FSM_PRESSED = 2'd1,
    FSM_LATCHED = 2'd2
  } fsm_state_e;

  // Next mode in the cycle 0..num_modes-1, wrapping back to MODE_SHIFT.
  function automatic mode_t next_mode(input mode_t m, input int num_modes);
    return (int'(m) == num_modes - 1) ? MODE_SHIFT : mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/mode_select_if.sv
// Button/mode bus between the mode selector and its surroundings.
// master drives the raw button and hold; slave (mode_select) returns
// the mode, its change strobe and the debounced button level.
interface mode_select_if;
  import led_anim_pkg::*;

  logic  btn;
  logic  hold;
  mode_t mode;
  logic  mode_chg;
  logic  btn_level;

  modport master (output btn, hold, input mode, mode_chg, btn_level);
  modport slave  (input btn, hold, output mode, mode_chg, btn_level);

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus level debouncer for one push-button.
// A new level is accepted only after DEB_CYCLES consecutive synchronised
// samples at that level; any reversion restarts the count.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_level
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_reg;
  logic          btn_s_reg;
  logic [CW-1:0] cnt_reg;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      btn_s_reg <= 1'b0;
    end else begin
      sync1_reg <= btn;
      btn_s_reg <= sync1_reg;
    end
  end

  // Count samples that disagree with the accepted level; toggle once the
  // disagreement has lasted DEB_CYCLES samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      btn_level <= 1'b0;
    end else if (btn_s_reg == btn_level) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
      cnt_reg   <= '0;
      btn_level <= ~btn_level;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mode_select.sv
// Animation mode selector: debounced button presses advance the 2-bit
// mode (wrapping at NUM_MODES), with a one-cycle strobe on every change.
// Optional feature macro MODE_LONGPRESS_EN: holding the button for
// LONG_CYCLES after a press returns the mode to 0 once per press.
module mode_select
  import led_anim_pkg::*;
#(
  parameter int DEB_CYCLES  = 16,
  parameter int NUM_MODES   = 4,
  parameter int LONG_CYCLES = 64
) (
  input logic          clk,
  input logic          rst,
  mode_select_if.slave bus
);

  localparam logic [1:0] IDLE    = FSM_IDLE;
  localparam logic [1:0] PRESSED = FSM_PRESSED;
  localparam logic [1:0] LATCHED = FSM_LATCHED;

  logic       btn_level;
  logic [1:0] state_reg, state_next;
  mode_t      mode_reg, mode_next;
  logic       mode_chg_reg;

`ifdef MODE_LONGPRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  logic [LW-1:0] long_reg, long_next;
`endif

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .btn       (bus.btn),
    .btn_level (btn_level)
  );

  // Press FSM: a rising debounced level advances the mode unless frozen.
  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
`ifdef MODE_LONGPRESS_EN
    long_next  = '0;
`endif
    case (state_reg)
      IDLE: begin
        if (btn_level) begin
`ifdef MODE_LONGPRESS_EN
          state_next = PRESSED;
`else
          state_next = LATCHED;
`endif
          if (!bus.hold) mode_next = next_mode(mode_reg, NUM_MODES);
        end
      end
`ifdef MODE_LONGPRESS_EN
      PRESSED: begin
        if (!btn_level) begin
          state_next = IDLE;
        end else if (long_reg == LW'(LONG_CYCLES - 1)) begin
          state_next = LATCHED;
          if (!bus.hold) mode_next = MODE_SHIFT;
        end else begin
          long_next = long_reg + 1'b1;
        end
      end
`endif
      LATCHED: begin
        if (!btn_level) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, mode and change strobe; the strobe fires only on a real change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      mode_reg     <= MODE_SHIFT;
      mode_chg_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      mode_chg_reg <= (mode_next != mode_reg);
    end
  end

`ifdef MODE_LONGPRESS_EN
  // Long-press timer, running only while in PRESSED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) long_reg <= '0;
    else     long_reg <= long_next;
  end
`endif

  assign bus.mode      = mode_reg;
  assign bus.mode_chg  = mode_chg_reg;
  assign bus.btn_level = btn_level;

endmodule

// File: doc/mode_select.md
# mode_select

Front-end stage that produces the 2-bit animation `mode` consumed by the LED animation top level. It synchronises and debounces a raw push-button and advances `mode` by one on each accepted press, wrapping at `NUM_MODES`. It also emits a one-cycle change strobe so downstream logic can restart cleanly.

## Interface
- `DEB_CYCLES`, 16: consecutive synchronised samples a new button level must hold before it is accepted; legal range 2..65535.
- `NUM_MODES`, 4: number of modes cycled through, 0..`NUM_MODES`-1; legal 2..4.
- `LONG_CYCLES`, 64: hold length after an accepted press that triggers the long-press return to mode 0; only used with `MODE_LONGPRESS_EN`.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `btn`  in  1  raw push-button, active-high, asynchronous to `clk`, bouncy.
- `hold`  in  1  synchronous freeze; while high, accepted presses do not change `mode`.
- `mode`  out  2  current mode, registered.
- `mode_chg`  out  1  one-cycle pulse in the cycle `mode` takes a new value.
- `btn_level`  out  1  debounced button level, registered.

## Operation
- **Synchroniser:** two flops, `btn` to `btn_s`; reset to 0.
- **Debouncer:**
  - Counter width is `$clog2(DEB_CYCLES+1)`.
  - If `btn_s` equals `btn_level`, the counter clears.
  - Otherwise it increments. When it reaches `DEB_CYCLES`-1 on a cycle where `btn_s` still differs, `btn_level` toggles on that edge and the counter clears.
  - Any reversion before that point clears the counter, so no glitch shorter than `DEB_CYCLES` samples propagates.
- **FSM states:**
  - IDLE: `btn_level`=0.
  - PRESSED: `btn_level`=1, long-press counter running.
  - LATCHED: `btn_level`=1, long-press already served or feature disabled.
- **Transitions:**
  - IDLE→PRESSED on a `btn_level` rising edge. Apply the increment at the same time.
  - PRESSED→LATCHED when the long counter reaches `LONG_CYCLES`-1.
  - PRESSED/LATCHED→IDLE on a `btn_level` falling edge.
- **Increment:** `mode` ← (`mode`==`NUM_MODES`-1) ? 0 : `mode`+1.
  - Suppressed when `hold`=1 in the rising-edge cycle. The press is consumed, not queued.
- `mode_chg`=1 exactly when the registered `mode` value differs from its previous value; never asserted for a suppressed or no-op update.
- **Reset mid-press:** all state returns to reset values. A button still held after reset release must first be debounced high, and it then counts as a new press.

## Timing
- **Reset values:** `mode`=0, `mode_chg`=0, `btn_level`=0, FSM=IDLE, all counters 0.
- **Press latency:** `btn` high and stable from edge 0 gives `btn_s`=1 after edge 2. `btn_level` rises at edge 2+`DEB_CYCLES`. `mode`/`mode_chg` update at edge 3+`DEB_CYCLES`.
- **Release** follows the same debounce path. It never changes `mode`.
- **`mode_chg` width:** exactly one cycle. Back-to-back pulses are impossible; the minimum spacing is 2·`DEB_CYCLES` cycles.
- **`hold`** is sampled in the same cycle as the rising edge of `btn_level`.

## Configuration
- **`MODE_LONGPRESS_EN` defined:**
  - If `btn_level` stays 1 for `LONG_CYCLES` cycles after the rising edge, `mode` ← 0 on the following edge.
  - `mode_chg` pulses only if `mode` was nonzero.
  - `hold`=1 in that cycle suppresses the reset.
  - The FSM then enters LATCHED. At most one long-press event occurs per press.
- **Undefined:** the long counter and the PRESSED→LATCHED arc are removed, and the FSM goes IDLE→LATCHED directly. `LONG_CYCLES` is ignored.

## Structure
- **Shared package `led_anim_pkg`:**
  - Mode encodings `MODE_SHIFT`=0, `MODE_FILL`=1, `MODE_PWM`=2, `MODE_OFF`=3.
  - The `mode_t` 2-bit typedef.
  - The FSM state enum.
- **Sub-module `btn_debounce`:** synchroniser plus debouncer, parameter `DEB_CYCLES`, output `btn_level`. It is reusable for future buttons.
- The top of this block holds the FSM, the mode register and the long-press counter.

## Test plan
- **Reset, then clean press:** apply `rst`, then `btn`=1 for 40 cycles with `DEB_CYCLES`=16. Required: `mode` 0→1 at edge 19 after the rise, `mode_chg` high for exactly one cycle, `btn_level`=1 at edge 18.
- **Bounce rejection:** `btn` toggling every 5 cycles for 100 cycles. Required: `btn_level` stays 0, `mode` stays 0, no `mode_chg`.
- **Wrap:** four clean presses with `NUM_MODES`=4 give `mode` 1,2,3,0 and four `mode_chg` pulses. With `NUM_MODES`=3, three presses give 1,2,0.
- **Hold suppression:** press with `hold`=1. Required: `mode` unchanged, no pulse. A second press with `hold`=0 increments.
- **Long press (`MODE_LONGPRESS_EN`, `LONG_CYCLES`=64):** from `mode`=2, hold `btn` for 120 cycles. Required: `mode`=3, then `mode`=0, 64 cycles later one more pulse, and nothing further until release.
- **Reset mid-press:** assert `rst` while `btn_level`=1 and `mode`=2. Required: outputs return to 0 immediately. With `btn` still held after reset release, `mode` becomes 1 after 3+`DEB_CYCLES` cycles.
